// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: sequences one external 4-bit adder slice over WORDS nibbles, LSB first
// Ports: start/sub/op_a/op_b/cin request an add (A+B+cin) or subtract (A-B);
//   busy is high while nibbles are processed; done pulses one cycle with sum/cout valid;
//   add_a/add_b/add_cin drive the external adder; add_s/add_cout return its result.
module nibble_serial_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sub,
  input  logic [4*WORDS-1:0] op_a,
  input  logic [4*WORDS-1:0] op_b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [4*WORDS-1:0] sum,
  output logic               cout,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  output logic               add_cin,
  input  logic [3:0]         add_s,
  input  logic               add_cout
);
  localparam int W = 4 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, last, accept;
  assign last = idx == LAST;
  // a request is taken in IDLE and also in DONE, which allows back-to-back ops
  assign accept = start && state != RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    busy = state == RUN;
    done = state == DONE;
    add_a = (state == RUN) ? a_r[{idx, 2'b00} +: 4] : 4'h0;
    add_b = (state == RUN) ? b_r[{idx, 2'b00} +: 4] : 4'h0;
    add_cin = (state == RUN) && carry;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_r <= op_a;
      b_r <= sub ? ~op_b : op_b;
      carry <= sub | cin;
      idx <= '0;
      sum <= '0;
    end else if (state == RUN) begin
      sum[{idx, 2'b00} +: 4] <= add_s;
      carry <= add_cout;
      idx <= last ? '0 : idx + 1'b1;
      if (last) cout <= add_cout;
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed checks of the serial add controller with a behavioural adder slice
module tb_nibble_serial_add_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, sum;
  logic busy, done, cout, add_cin, add_cout;
  logic [3:0] add_a, add_b, add_s;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  nibble_serial_add_ctrl #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .add_a(add_a),
    .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c, input logic [3:0] ea0, input logic [3:0] eb0,
                        input logic ec0, input logic [15:0] es, input logic ec);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_add_a0"}, add_a, ea0);
    chk({tag, "_add_b0"}, add_b, eb0);
    chk({tag, "_add_cin0"}, add_cin, ec0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_add_a_idle"}, add_a, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_sum_held"}, sum, es);
  endtask
  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    run_op("t1", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 4'h4, 4'hD, 1'b0, 16'h2201, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'hF, 4'h1, 1'b0, 16'h0000, 1'b1);
    run_op("t2c", 16'h00FF, 16'h0100, 1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 16'h0200, 1'b0);
    run_op("t3a", 16'h0005, 16'h0007, 1'b1, 1'b0, 4'h5, 4'h8, 1'b1, 16'hFFFE, 1'b0);
    run_op("t3b", 16'h0007, 16'h0005, 1'b1, 1'b0, 4'h7, 4'hA, 1'b1, 16'h0002, 1'b1);
    // start pulsed throughout RUN with changing operands
    op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy0", busy, 1);
    op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1; cin = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t4_busy", busy, 1);
      op_a = op_a + 16'h0101; op_b = op_b ^ 16'hFFFF; sub = ~sub; cin = ~cin;
      if (i == 3) start = 1'b0;
    end
    @(posedge clk); #1;
    chk("t4_done", done, 1);
    chk("t4_busy_end", busy, 0);
    chk("t4_sum", sum, 16'h3333);
    chk("t4_cout", cout, 0);
    @(posedge clk); #1;
    chk("t4_idle", {busy, done}, 0);
    // start held high through DONE: back-to-back operations
    op_a = 16'h000F; op_b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h8000; op_b = 16'h8000;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5_busy", busy, 1);
    end
    @(posedge clk); #1;
    chk("t5_done1", done, 1);
    chk("t5_sum1", sum, 16'h0010);
    chk("t5_cout1", cout, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_done", done, 0);
    chk("t5_restart_sum", sum, 0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5_busy2", busy, 1);
    end
    @(posedge clk); #1;
    chk("t5_done2", done, 1);
    chk("t5_sum2", sum, 16'h0000);
    chk("t5_cout2", cout, 1);
    @(posedge clk); #1;
    // reset in the middle of a run, at idx=2
    op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_idx2_add_a", add_a, 4'hF);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_sum", sum, 0);
    chk("t6_cout", cout, 0);
    chk("t6_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle", {busy, done}, 0);
    run_op("t6f", 16'h1234, 16'h1111, 1'b0, 1'b0, 4'h4, 4'h1, 1'b0, 16'h2345, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
